// File: rtl/fifo_pkg.sv
// Shared constants and the RAM operation encoding for the FIFO controller.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = 5;

  // Which RAM access the controller drives this cycle; exported for debug.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } ram_op_e;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// Push/pop handshakes, status and the single-port RAM bus of the FIFO controller.
interface fifo_ram_ctrl_if;
  import fifo_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  ram_op_e           ram_op;

  // Controller side.
  modport master (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data, count, full, empty,
           ram_cs, ram_we, ram_addr, ram_wdata, ram_op
  );

  // Producer / consumer / RAM side.
  modport slave (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data, count, full, empty,
           ram_cs, ram_we, ram_addr, ram_wdata, ram_op
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer: increments by one when enabled, rolls over at 2**W.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Next pointer value; natural overflow gives the modulo wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller in front of a 16x8 single-port synchronous RAM.
// Keeps one prefetched word in the RAM read register (out_data is ram_rdata),
// so the RAM's read data must persist across write and idle cycles. A refill
// read always wins over a push because a single port serves both.
module fifo_ram_ctrl
  import fifo_pkg::*;
(
  input  logic            ck,
  input  logic            rst_n,
  fifo_ram_ctrl_if.master bus
);

  logic [ADDR_W:0]   mem_count_q;
  logic [ADDR_W:0]   mem_count_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_issue;
  logic              wr_issue;
  logic              in_ready;

  localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);

  fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
    .ck    (ck),
    .rst_n (rst_n),
    .inc_i (wr_issue),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
    .ck    (ck),
    .rst_n (rst_n),
    .inc_i (rd_issue),
    .ptr_o (rd_ptr)
  );

  // Access arbitration: refill read first, push only when the port is free.
  // rst_n gating keeps the RAM quiet and pushes refused while in reset.
  always_comb begin
    rd_issue = rst_n && (mem_count_q != '0) && (!out_valid_q || bus.out_ready);
    in_ready = rst_n && (mem_count_q != MEM_FULL) && !rd_issue;
    wr_issue = bus.in_valid && in_ready;
  end

  // Occupancy and output-register bookkeeping.
  always_comb begin
    mem_count_d = mem_count_q;
    if (wr_issue)      mem_count_d = mem_count_q + 1'b1;
    else if (rd_issue) mem_count_d = mem_count_q - 1'b1;

    out_valid_d = out_valid_q;
    if (rd_issue)           out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  // State registers; async reset drops out_valid without a clock edge.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      mem_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM bus drive; idle cycles park the address on rd_ptr.
  always_comb begin
    bus.ram_cs   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = rd_ptr;
    bus.ram_op   = OP_IDLE;
    if (rd_issue) begin
      bus.ram_cs   = 1'b1;
      bus.ram_op   = OP_RD;
    end else if (wr_issue) begin
      bus.ram_cs   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = wr_ptr;
      bus.ram_op   = OP_WR;
    end
  end

  // Handshake and status outputs.
  always_comb begin
    bus.ram_wdata = bus.in_data;
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.out_data  = bus.ram_rdata;
    bus.count     = CNT_W'(mem_count_q) + CNT_W'(out_valid_q);
    bus.full      = (mem_count_q == MEM_FULL);
    bus.empty     = (mem_count_q == '0) && !out_valid_q;
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl with a behavioural single-port RAM.
module tb_fifo_ram_ctrl;
  import fifo_pkg::*;

  logic ck;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  fifo_ram_ctrl_if bus();

  fifo_ram_ctrl u_dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata_q;

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    ram_rdata_q = '0;
  end

  // RAM model: registered read data, held when not reading.
  always @(posedge ck) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_rdata_q <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = ram_rdata_q;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge ck); #1;
    rst_n = 1'b1;
  endtask

  // Offers one word and waits (bounded) until it is accepted.
  task automatic push_word(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge ck); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge ck); #1;
    end
    check_val("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int pushed, popped, wr_m, rd_m;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    @(posedge ck); #1;
    check_val("rst_count", 32'(bus.count), 0);
    check_val("rst_empty", 32'(bus.empty), 1);
    check_val("rst_full", 32'(bus.full), 0);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    #1;
    check_val("rst_ram_cs", 32'(bus.ram_cs), 0);
    check_val("rst_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    @(posedge ck); #1;
    rst_n = 1'b1;
    #1;
    check_val("idle_in_ready", 32'(bus.in_ready), 1);

    // Single push, prefetch to the output register.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    check_val("p1_cs", 32'(bus.ram_cs), 1);
    check_val("p1_we", 32'(bus.ram_we), 1);
    check_val("p1_addr", 32'(bus.ram_addr), 0);
    check_val("p1_op", 32'(bus.ram_op), 32'(OP_WR));
    @(posedge ck); #1;
    bus.in_valid = 1'b0;
    #1;
    check_val("p1_rd_cs", 32'(bus.ram_cs), 1);
    check_val("p1_rd_we", 32'(bus.ram_we), 0);
    check_val("p1_rd_addr", 32'(bus.ram_addr), 0);
    check_val("p1_rd_in_ready", 32'(bus.in_ready), 0);
    @(posedge ck); #1; #1;
    check_val("p1_out_valid", 32'(bus.out_valid), 1);
    check_val("p1_out_data", 32'(bus.out_data), 32'hA5);
    check_val("p1_count", 32'(bus.count), 1);
    check_val("p1_empty", 32'(bus.empty), 0);

    // Fill to DEPTH+1 under backpressure.
    do_reset();
    for (int i = 0; i <= 16; i++) push_word(8'(i));
    #1;
    check_val("fill_count", 32'(bus.count), 17);
    check_val("fill_full", 32'(bus.full), 1);
    check_val("fill_out_data", 32'(bus.out_data), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    #1;
    check_val("fill_in_ready", 32'(bus.in_ready), 0);
    repeat (3) @(posedge ck);
    #1;
    check_val("fill_held_count", 32'(bus.count), 17);
    check_val("fill_held_data", 32'(bus.out_data), 0);
    check_val("fill_held_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;

    // Drain from full.
    bus.out_ready = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 17; cyc++) begin
      #1;
      if (bus.ram_cs && !bus.ram_we) check_val("drain_in_ready", 32'(bus.in_ready), 0);
      if (bus.out_valid) begin
        check_val("drain_data", 32'(bus.out_data), 32'(idx));
        idx++;
      end
      @(posedge ck);
    end
    #1;
    check_val("drain_words", 32'(idx), 17);
    check_val("drain_empty", 32'(bus.empty), 1);
    check_val("drain_count", 32'(bus.count), 0);

    // Simultaneous push/pop with count=5.
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'(8'h20 + i));
    #1;
    check_val("sim_count5", 32'(bus.count), 5);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h30;
    bus.out_ready = 1'b1;
    #1;
    check_val("sim_rd_cs", 32'(bus.ram_cs), 1);
    check_val("sim_rd_we", 32'(bus.ram_we), 0);
    check_val("sim_rd_addr", 32'(bus.ram_addr), 1);
    check_val("sim_in_ready0", 32'(bus.in_ready), 0);
    check_val("sim_head", 32'(bus.out_data), 32'h20);
    @(posedge ck); #1;
    bus.out_ready = 1'b0;
    #1;
    check_val("sim_in_ready1", 32'(bus.in_ready), 1);
    check_val("sim_wr_we", 32'(bus.ram_we), 1);
    check_val("sim_wr_addr", 32'(bus.ram_addr), 5);
    check_val("sim_head2", 32'(bus.out_data), 32'h21);
    @(posedge ck); #1;
    bus.in_valid = 1'b0;
    #1;
    check_val("sim_count_after", 32'(bus.count), 5);

    // Asynchronous reset mid-stream with count=9.
    for (int i = 0; i < 4; i++) push_word(8'(8'h31 + i));
    #1;
    check_val("mid_count9", 32'(bus.count), 9);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    #1;
    check_val("mid_out_valid", 32'(bus.out_valid), 0);
    check_val("mid_count", 32'(bus.count), 0);
    check_val("mid_empty", 32'(bus.empty), 1);
    check_val("mid_cs", 32'(bus.ram_cs), 0);
    check_val("mid_in_ready", 32'(bus.in_ready), 0);
    @(posedge ck); #1;
    check_val("mid_cs_hold", 32'(bus.ram_cs), 0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_we", 32'(bus.ram_we), 1);
    check_val("post_rst_addr", 32'(bus.ram_addr), 0);
    @(posedge ck); #1;
    bus.in_valid = 1'b0;
    @(posedge ck); #1; #1;
    check_val("post_rst_valid", 32'(bus.out_valid), 1);
    check_val("post_rst_data", 32'(bus.out_data), 32'h77);
    bus.out_ready = 1'b1;
    @(posedge ck); #1; #1;
    check_val("post_rst_empty", 32'(bus.empty), 1);

    // Random valid/ready across the pointer wrap.
    do_reset();
    pushed = 0; popped = 0; wr_m = 0; rd_m = 0;
    for (int cyc = 0; cyc < 2000 && popped < 40; cyc++) begin
      bus.in_valid  = (pushed < 40) && ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'(8'h40 + pushed);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check_val("wrap_count", 32'(bus.count), 32'(exp_q.size()));
      check_val("wrap_wr_sync", 32'(bus.ram_cs && bus.ram_we), 32'(bus.in_valid && bus.in_ready));
      if (bus.ram_cs && bus.ram_we) check_val("wrap_waddr", 32'(bus.ram_addr), 32'(wr_m % 16));
      if (bus.ram_cs && !bus.ram_we) begin
        check_val("wrap_raddr", 32'(bus.ram_addr), 32'(rd_m % 16));
        rd_m++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        pushed++;
        wr_m++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("wrap_underflow", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check_val("wrap_data", 32'(bus.out_data), 32'(exp_d));
        end
        popped++;
      end
      @(posedge ck); #1;
    end
    check_val("wrap_pushed", 32'(pushed), 40);
    check_val("wrap_popped", 32'(popped), 40);
    check_val("wrap_rd_wrapped", 32'(rd_m > 16), 1);
    #1;
    check_val("wrap_empty", 32'(bus.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
